// File: rtl/nau_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nau_pkg                                                            |
// | Shared defaults, address type and command encodings for the        |
// | next-address unit.                                                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package nau_pkg;

    localparam int NAU_ADDR_W    = 10;
    localparam int NAU_RAS_DEPTH = 8;

    typedef logic [NAU_ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000,
        OP_JMP  = 3'b001,
        OP_BR   = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100
    } nau_op_e;

endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ret_stack                                                          |
// | Parameterised LIFO return-address stack; pushes when full and      |
// | pops when empty are ignored.                                       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ret_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        top,
    output logic [$clog2(DEPTH):0]  depth,
    output logic                    full,
    output logic                    empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W:0]   r_cnt;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic [c_PTR_W-1:0] w_top_idx;

    assign w_wr_idx  = r_cnt[c_PTR_W-1:0];
    assign w_top_idx = w_wr_idx - c_PTR_W'(1);

    assign full  = (r_cnt == c_FULL);
    assign empty = (r_cnt == '0);
    assign depth = r_cnt;
    // An empty stack reads as zero so callers never see stale entries.
    assign top   = empty ? '0 : r_mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push && !full) begin
            r_mem[w_wr_idx] <= din;
            r_cnt           <= r_cnt + (c_PTR_W + 1)'(1);
        end else if (pop && !empty) begin
            r_cnt <= r_cnt - (c_PTR_W + 1)'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/next_addr_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | next_addr_unit                                                     |
// | Next-PC generator: step, jump, branch, call and return with an     |
// | internal return-address stack and sticky fault flags.              |
// | Build option: define NEXT_ADDR_TRAP_EN to redirect stack faults    |
// | to TRAP_VECTOR.                                                    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module next_addr_unit
    import nau_pkg::*;
#(
    parameter int                   ADDR_W      = NAU_ADDR_W,
    parameter int                   RAS_DEPTH   = NAU_RAS_DEPTH,
    parameter logic [ADDR_W-1:0]    TRAP_VECTOR = ADDR_W'(10'h3F0)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hlt,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [2:0]        op,
    input  logic              cond,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        depth,
    output logic              ovf,
    output logic              unf
);

    localparam int c_CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_top;
    logic [c_CNT_W-1:0] w_depth;
    logic               w_full;
    logic               w_empty;
    logic               w_is_call;
    logic               w_is_ret;
    logic               w_ovf_evt;
    logic               w_unf_evt;
    logic               w_push;
    logic               w_pop;
    logic               r_ovf;
    logic               r_unf;

    assign w_pc_inc  = pc_in + ADDR_W'(1);
    assign w_is_call = (op == OP_CALL);
    assign w_is_ret  = (op == OP_RET);
    assign w_ovf_evt = w_is_call && w_full;
    assign w_unf_evt = w_is_ret && w_empty;
    assign w_push    = !hlt && w_is_call && !w_full;
    assign w_pop     = !hlt && w_is_ret && !w_empty;

    ret_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .top   (w_top),
        .depth (w_depth),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        address = w_pc_inc;
        case (op)
            OP_JMP:  address = target;
            OP_BR:   address = cond ? target : w_pc_inc;
            OP_CALL: begin
`ifdef NEXT_ADDR_TRAP_EN
                address = w_full ? TRAP_VECTOR : target;
`else
                address = target;
`endif
            end
            OP_RET: begin
`ifdef NEXT_ADDR_TRAP_EN
                address = w_empty ? TRAP_VECTOR : w_top;
`else
                address = w_empty ? w_pc_inc : w_top;
`endif
            end
            default: address = w_pc_inc;
        endcase
        if (reset) begin
            address = '0;
        end
    end

`ifndef NEXT_ADDR_TRAP_EN
    logic w_unused_trap;
    assign w_unused_trap = ^TRAP_VECTOR;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (!hlt) begin
            if (w_ovf_evt) r_ovf <= 1'b1;
            if (w_unf_evt) r_unf <= 1'b1;
        end
    end

    assign ovf   = r_ovf;
    assign unf   = r_unf;
    assign depth = 4'(w_depth);

endmodule
`default_nettype wire

// File: tb/tb_next_addr_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_next_addr_unit                                                  |
// | Directed self-checking bench for next_addr_unit (both trap builds).|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_next_addr_unit;

    localparam logic [2:0] c_SEQ  = 3'b000;
    localparam logic [2:0] c_JMP  = 3'b001;
    localparam logic [2:0] c_BR   = 3'b010;
    localparam logic [2:0] c_CALL = 3'b011;
    localparam logic [2:0] c_RET  = 3'b100;
    localparam logic [9:0] c_TRAP = 10'h3F0;

    logic       clk = 1'b0;
    logic       reset;
    logic       hlt;
    logic [9:0] pc_in;
    logic [2:0] op;
    logic       cond;
    logic [9:0] target;
    logic [9:0] address;
    logic [3:0] depth;
    logic       ovf;
    logic       unf;

    int n_cmp = 0;
    int n_err = 0;

    next_addr_unit dut (
        .clk     (clk),
        .reset   (reset),
        .hlt     (hlt),
        .pc_in   (pc_in),
        .op      (op),
        .cond    (cond),
        .target  (target),
        .address (address),
        .depth   (depth),
        .ovf     (ovf),
        .unf     (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change mid-low-phase; combinational address is sampled 1ns later.
    task automatic drive(input logic [2:0] o, input logic [9:0] pc, input logic [9:0] tgt,
                         input logic c, input logic h);
        @(negedge clk);
        op = o; pc_in = pc; target = tgt; cond = c; hlt = h;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] exp_addr;
        reset = 1'b1; hlt = 1'b0; pc_in = '0; op = c_SEQ; cond = 1'b0; target = '0;
        tick();
        tick();

        // Reset held during a CALL: push discarded, address forced low.
        drive(c_CALL, 10'h020, 10'h100, 1'b0, 1'b0);
        chk("rst_addr", 32'(address), 32'h0);
        tick();
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_unf", 32'(unf), 32'd0);

        reset = 1'b0;
        drive(c_SEQ, 10'h3FF, 10'h000, 1'b0, 1'b0);
        chk("seq_wrap", 32'(address), 32'h000);
        tick();

        drive(c_BR, 10'h010, 10'h040, 1'b1, 1'b0);
        chk("br_taken", 32'(address), 32'h040);
        drive(c_BR, 10'h010, 10'h040, 1'b0, 1'b0);
        chk("br_not_taken", 32'(address), 32'h011);
        drive(c_JMP, 10'h005, 10'h123, 1'b1, 1'b0);
        chk("jmp", 32'(address), 32'h123);
        drive(3'b111, 10'h0AA, 10'h222, 1'b1, 1'b0);
        chk("op7_as_seq", 32'(address), 32'h0AB);
        tick();
        chk("op7_depth", 32'(depth), 32'd0);

        drive(c_CALL, 10'h020, 10'h100, 1'b0, 1'b0);
        chk("call_addr", 32'(address), 32'h100);
        tick();
        chk("call_depth", 32'(depth), 32'd1);
        drive(c_RET, 10'h100, 10'h000, 1'b0, 1'b0);
        chk("ret_addr", 32'(address), 32'h021);
        tick();
        chk("ret_depth", 32'(depth), 32'd0);

        for (int i = 0; i < 9; i++) begin
            drive(c_CALL, 10'(i), 10'h200 + 10'(i), 1'b0, 1'b0);
`ifdef NEXT_ADDR_TRAP_EN
            exp_addr = (i == 8) ? c_TRAP : 10'h200 + 10'(i);
`else
            exp_addr = 10'h200 + 10'(i);
`endif
            chk("call_n_addr", 32'(address), 32'(exp_addr));
            tick();
            chk("call_n_depth", 32'(depth), (i < 8) ? 32'(i + 1) : 32'd8);
            chk("call_n_ovf", 32'(ovf), (i == 8) ? 32'd1 : 32'd0);
        end

        drive(c_RET, 10'h200, 10'h000, 1'b0, 1'b0);
        chk("pop8_addr", 32'(address), 32'h008);
        tick();
        chk("pop8_depth", 32'(depth), 32'd7);

        // Halted commands still produce an address but leave state alone.
        drive(c_CALL, 10'h300, 10'h111, 1'b0, 1'b1);
        chk("hlt_call_addr", 32'(address), 32'h111);
        tick();
        chk("hlt_call_depth", 32'(depth), 32'd7);
        drive(c_RET, 10'h300, 10'h000, 1'b0, 1'b1);
        chk("hlt_ret_addr", 32'(address), 32'h007);
        tick();
        chk("hlt_ret_depth", 32'(depth), 32'd7);

        for (int k = 7; k >= 1; k--) begin
            drive(c_RET, 10'h300, 10'h000, 1'b0, 1'b0);
            chk("pop_addr", 32'(address), 32'(k));
            tick();
            chk("pop_depth", 32'(depth), 32'(k - 1));
        end
        chk("pop_unf_clear", 32'(unf), 32'd0);

        drive(c_RET, 10'h055, 10'h000, 1'b0, 1'b0);
`ifdef NEXT_ADDR_TRAP_EN
        chk("unf_addr", 32'(address), 32'(c_TRAP));
`else
        chk("unf_addr", 32'(address), 32'h056);
`endif
        tick();
        chk("unf_flag", 32'(unf), 32'd1);
        chk("unf_depth", 32'(depth), 32'd0);
        chk("ovf_sticky", 32'(ovf), 32'd1);

        drive(c_SEQ, 10'h001, 10'h000, 1'b0, 1'b0);
        tick();
        chk("unf_sticky", 32'(unf), 32'd1);

        drive(c_CALL, 10'h030, 10'h150, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_call_addr", 32'(address), 32'h0);
        tick();
        chk("rst_call_depth", 32'(depth), 32'd0);
        chk("rst_call_ovf", 32'(ovf), 32'd0);
        chk("rst_call_unf", 32'(unf), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
